// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-4 Booth 8x8 multiplier, one shared encoder, valid/ready in and out
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_a/in_b operand handshake;
//        abort cancels the operation in flight; out_valid/out_ready/out_prod result handshake;
//        busy is high whenever the block is not idle.
module booth_enc (
  input  logic [8:0] src_data,
  input  logic [2:0] code,
  output logic [9:0] out_data,
  output logic       out_inv
);
  logic [9:0] mag, v;
  always_comb begin
    mag = (code == 3'b011 || code == 3'b100) ? {src_data, 1'b0} :
          (code == 3'b000 || code == 3'b111) ? 10'd0 : {src_data[8], src_data};
    out_inv = code[2] & ~(code[1] & code[0]);
    v = out_inv ? ~mag : mag;
    // Inverted sign bit lets the accumulator sign-extend with a single fixed rule.
    out_data = {~v[9], v[8:0]};
  end
endmodule

module booth_mul_seq #(
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_prod,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [2:0] LAST = SIGNED_EN ? 3'd3 : 3'd4;
  state_t      state_q, state_d;
  logic [8:0]  src_q, src_d;
  logic [10:0] mplr_q, mplr_d;
  logic [17:0] acc_q, acc_d, pp, acc_sum;
  logic [2:0]  step_q, step_d, code;
  logic [9:0]  enc_data;
  logic        enc_inv;
  logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic [15:0] out_prod_q, out_prod_d;
  // mplr carries one extra copy of the extension bit so the fifth unsigned digit stays in range.
  assign code = mplr_q[{step_q, 1'b0} +: 3];
  booth_enc u_enc (.src_data(src_q), .code(code), .out_data(enc_data), .out_inv(enc_inv));
  always_comb begin
    pp = {{8{~enc_data[9]}}, ~enc_data[9], enc_data[8:0]} + {17'd0, enc_inv};
    acc_sum = acc_q + (pp << {step_q, 1'b0});
    state_d = state_q;
    src_d = src_q;
    mplr_d = mplr_q;
    acc_d = acc_q;
    step_d = step_q;
    out_valid_d = out_valid_q;
    out_prod_d = out_prod_q;
    if (state_q == IDLE) begin
      if (in_valid) begin
        state_d = CALC;
        src_d = {SIGNED_EN & in_a[7], in_a};
        mplr_d = {{2{SIGNED_EN & in_b[7]}}, in_b, 1'b0};
        acc_d = 18'd0;
        step_d = 3'd0;
      end
    end else if (abort) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
    end else if (state_q == CALC) begin
      acc_d = acc_sum;
      step_d = step_q + 3'd1;
      if (step_q == LAST) begin
        state_d = DONE;
        out_valid_d = 1'b1;
        out_prod_d = acc_sum[15:0];
      end
    end else if (out_ready) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
    end
    in_ready_d = state_d == IDLE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q <= 9'd0;
      mplr_q <= 11'd0;
      acc_q <= 18'd0;
      step_q <= 3'd0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_prod_q <= 16'd0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      mplr_q <= mplr_d;
      acc_q <= acc_d;
      step_q <= step_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_prod_q <= out_prod_d;
      busy_q <= busy_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_prod = out_prod_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: checks unsigned (index 0) and signed (index 1) instances against a behavioural model
module tb_booth_mul_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid[2], in_ready[2], abort[2], out_valid[2], out_ready[2], busy[2];
  logic [7:0] in_a[2], in_b[2];
  logic [15:0] out_prod[2];
  int vecs = 0, miscmp = 0;
  int m_st[2], m_cnt[2];
  logic m_ov[2];
  logic [15:0] m_prod[2], m_outp[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    booth_mul_seq #(.SIGNED_EN(g == 1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_a(in_a[g]), .in_b(in_b[g]), .abort(abort[g]), .out_valid(out_valid[g]),
      .out_ready(out_ready[g]), .out_prod(out_prod[g]), .busy(busy[g])
    );
  end

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_prod(int k, logic [7:0] a, logic [7:0] b);
    int p;
    p = (k == 1) ? int'($signed(a)) * int'($signed(b)) : int'(a) * int'(b);
    return p[15:0];
  endfunction

  task automatic chk(string nm, int k, logic [15:0] act, logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  // Cycle-level model: accept in idle, product ready N edges later, held until taken or aborted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_st[k] <= 0;
        m_cnt[k] <= 0;
        m_ov[k] <= 1'b0;
        m_outp[k] <= 16'd0;
        m_prod[k] <= 16'd0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_st[k] == 0) begin
          if (in_valid[k]) begin
            m_st[k] <= 1;
            m_cnt[k] <= (k == 1) ? 4 : 5;
            m_prod[k] <= ref_prod(k, in_a[k], in_b[k]);
          end
        end else if (abort[k]) begin
          m_st[k] <= 0;
          m_ov[k] <= 1'b0;
        end else if (m_st[k] == 1) begin
          m_cnt[k] <= m_cnt[k] - 1;
          if (m_cnt[k] == 1) begin
            m_st[k] <= 2;
            m_ov[k] <= 1'b1;
            m_outp[k] <= m_prod[k];
          end
        end else if (out_ready[k]) begin
          m_st[k] <= 0;
          m_ov[k] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("in_ready", k, 16'(in_ready[k]), 16'(m_st[k] == 0));
      chk("busy", k, 16'(busy[k]), 16'(m_st[k] != 0));
      chk("out_valid", k, 16'(out_valid[k]), 16'(m_ov[k]));
      chk("out_prod", k, out_prod[k], m_outp[k]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(int k, output int n);
    n = 0;
    while (!out_valid[k] && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(int k, logic [7:0] a, logic [7:0] b, logic [15:0] exp, int lat);
    int n = 0;
    out_ready[k] = 1'b1;
    in_a[k] = a;
    in_b[k] = b;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && n < 50) begin
      step();
      n++;
    end
    step();
    in_valid[k] = 1'b0;
    wait_out(k, n);
    chk("latency", k, 16'(n), 16'(lat));
    chk("product", k, out_prod[k], exp);
    step();
  endtask

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      abort[k] = 1'b0;
      out_ready[k] = 1'b0;
      in_a[k] = 8'd0;
      in_b[k] = 8'd0;
    end
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", k, 16'(in_ready[k]), 16'd1);
      chk("rst_out_valid", k, 16'(out_valid[k]), 16'd0);
      chk("rst_busy", k, 16'(busy[k]), 16'd0);
      chk("rst_out_prod", k, out_prod[k], 16'd0);
    end
    chk("ref_s_min_min", 1, ref_prod(1, 8'h80, 8'h80), 16'h4000);
    chk("ref_s_5_m3", 1, ref_prod(1, 8'h05, 8'hFD), 16'hFFF1);
    chk("ref_u_255_255", 0, ref_prod(0, 8'hFF, 8'hFF), 16'hFE01);
    #11 rst_n = 1'b1;
    step();
    run_op(1, 8'h80, 8'h80, 16'h4000, 4);
    run_op(1, 8'h80, 8'h7F, 16'hC080, 4);
    run_op(1, 8'h05, 8'hFD, 16'hFFF1, 4);
    run_op(1, 8'h00, 8'hFF, 16'h0000, 4);
    run_op(0, 8'hFF, 8'hFF, 16'hFE01, 5);
    run_op(0, 8'h80, 8'h02, 16'h0100, 5);
    // Backpressure: result held while out_ready stays low.
    out_ready[1] = 1'b0;
    in_a[1] = 8'h7F;
    in_b[1] = 8'h81;
    in_valid[1] = 1'b1;
    step();
    in_valid[1] = 1'b0;
    wait_out(1, n);
    chk("bp_latency", 1, 16'(n), 16'd4);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_out_valid", 1, 16'(out_valid[1]), 16'd1);
      chk("bp_out_prod", 1, out_prod[1], 16'hC0FF);
      chk("bp_in_ready", 1, 16'(in_ready[1]), 16'd0);
    end
    out_ready[1] = 1'b1;
    in_a[1] = 8'h02;
    in_b[1] = 8'h03;
    in_valid[1] = 1'b1;
    step();
    chk("bp_release_in_ready", 1, 16'(in_ready[1]), 16'd1);
    chk("bp_release_out_valid", 1, 16'(out_valid[1]), 16'd0);
    step();
    in_valid[1] = 1'b0;
    chk("bp_next_accepted", 1, 16'(busy[1]), 16'd1);
    wait_out(1, n);
    chk("bp_next_prod", 1, out_prod[1], 16'h0006);
    step();
    // Abort during the third Booth digit.
    in_a[1] = 8'h11;
    in_b[1] = 8'h22;
    in_valid[1] = 1'b1;
    step();
    in_valid[1] = 1'b0;
    step();
    step();
    abort[1] = 1'b1;
    step();
    abort[1] = 1'b0;
    chk("abort_in_ready", 1, 16'(in_ready[1]), 16'd1);
    chk("abort_busy", 1, 16'(busy[1]), 16'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_valid", 1, 16'(out_valid[1]), 16'd0);
    end
    run_op(1, 8'h03, 8'h07, 16'h0015, 4);
    // Asynchronous reset in the middle of a calculation.
    in_a[1] = 8'h40;
    in_b[1] = 8'h40;
    in_valid[1] = 1'b1;
    step();
    in_valid[1] = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 1, 16'(in_ready[1]), 16'd1);
    chk("arst_busy", 1, 16'(busy[1]), 16'd0);
    chk("arst_out_valid", 1, 16'(out_valid[1]), 16'd0);
    chk("arst_out_prod", 1, out_prod[1], 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_op(1, 8'hFF, 8'hFF, 16'h0001, 4);
    // Random traffic on both instances, checked every cycle by the model compare.
    for (int c = 0; c < 30000; c++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k] = ($urandom % 3) != 0;
        in_a[k] = 8'($urandom);
        in_b[k] = 8'($urandom);
        out_ready[k] = ($urandom % 4) != 0;
        abort[k] = ($urandom % 32) == 0;
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      abort[k] = 1'b0;
      out_ready[k] = 1'b1;
    end
    repeat (10) step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
